pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the dynamic pipeline CPU, replacing the plain enable-gated PC register at the head of the IF stage. It holds the fetch PC and computes the next PC from sequential increment, branch, eret and exception redirects with fixed priority. It also latches any redirect that arrives while fetch is stalled, so the redirect is applied when the stall clears instead of being lost.

---
 rtl/pc_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer at the head of the IF stage. Holds the fetch PC and
// selects the next PC from the sequential increment and from the redirect
// requests. The requests are, in priority order: exception, eret, then branch.
// A redirect that arrives while fetch is stalled is latched in a one-entry
// pending register. It is applied on the first unstalled edge instead of being
// lost.
//
// Optional feature (macro PC_ALIGN_CHECK_EN):
//   When the macro is defined, an applied redirect whose target has bits [1:0]
//   not equal to 0 is replaced by EXC_VECTOR, and align_err pulses for one
//   cycle. When it is undefined, targets pass through unmodified and align_err
//   is tied to 0.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   stall          in   1 = hold PC this cycle
//   branch_valid   in   taken branch/jump redirect request
//   branch_target  in   branch/jump target
//   eret_valid     in   return-from-exception redirect request
//   eret_target    in   EPC value for eret
//   exc_valid      in   exception redirect request (to EXC_VECTOR)
//   pc             out  current fetch address (registered)
//   pending        out  a redirect is latched, awaiting stall release
//   redirected     out  pc was loaded from a redirect on the last edge
//   align_err      out  misaligned redirect replaced by EXC_VECTOR
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0040_0000),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0040_0004),
    parameter logic [WIDTH-1:0] STEP         = WIDTH'(4)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_valid,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             eret_valid,
    input  logic [WIDTH-1:0] eret_target,
    input  logic             exc_valid,
    output logic [WIDTH-1:0] pc,
    output logic             pending,
    output logic             redirected,
    output logic             align_err
);

    // The encoding order equals the priority order, so a plain magnitude
    // compare decides which request wins.
    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_BR   = 2'd1,
        CLS_ERET = 2'd2,
        CLS_EXC  = 2'd3
    } cls_t;

    cls_t             pend_cls,  pend_cls_d;
    logic [WIDTH-1:0] pend_tgt,  pend_tgt_d;
    logic [WIDTH-1:0] pc_d;
    logic             pending_d;
    logic             redirected_d;
    logic             align_err_d;

    cls_t             live_cls;
    logic [WIDTH-1:0] live_tgt;
    cls_t             apply_cls;
    logic [WIDTH-1:0] apply_tgt;
    logic             take_live;

    // Reduce the live requests to the single highest-priority one.
    always_comb begin
        live_cls = CLS_NONE;
        live_tgt = branch_target;
        if (exc_valid) begin
            live_cls = CLS_EXC;
            live_tgt = EXC_VECTOR;
        end else if (eret_valid) begin
            live_cls = CLS_ERET;
            live_tgt = eret_target;
        end else if (branch_valid) begin
            live_cls = CLS_BR;
        end
    end

    // The live request wins ties against the stored entry. It replaces the
    // entry during a stall and takes precedence at release.
    assign take_live = (live_cls != CLS_NONE) && (live_cls >= pend_cls);

    // Next-state selection.
    always_comb begin
        pc_d         = pc;
        pend_cls_d   = pend_cls;
        pend_tgt_d   = pend_tgt;
        redirected_d = 1'b0;
        align_err_d  = 1'b0;
        apply_cls    = pend_cls;
        apply_tgt    = pend_tgt;

        if (stall) begin
            if (take_live) begin
                pend_cls_d = live_cls;
                pend_tgt_d = live_tgt;
            end
        end else begin
            if (take_live) begin
                apply_cls = live_cls;
                apply_tgt = live_tgt;
            end
            pend_cls_d = CLS_NONE;
            pend_tgt_d = '0;

            if (apply_cls != CLS_NONE) begin
                redirected_d = 1'b1;
                pc_d         = apply_tgt;
`ifdef PC_ALIGN_CHECK_EN
                // EXC_VECTOR is trusted; only external targets are checked.
                if ((apply_cls != CLS_EXC) && (apply_tgt[1:0] != 2'b00)) begin
                    pc_d        = EXC_VECTOR;
                    align_err_d = 1'b1;
                end
`endif
            end else begin
                // Wraps modulo 2^WIDTH without any flag.
                pc_d = pc + STEP;
            end
        end

        pending_d = (pend_cls_d != CLS_NONE);
    end

    // State register: every output is registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc         <= RESET_VECTOR;
            pend_cls   <= CLS_NONE;
            pend_tgt   <= '0;
            pending    <= 1'b0;
            redirected <= 1'b0;
        end else begin
            pc         <= pc_d;
            pend_cls   <= pend_cls_d;
            pend_tgt   <= pend_tgt_d;
            pending    <= pending_d;
            redirected <= redirected_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            align_err <= 1'b0;
        end else begin
            align_err <= align_err_d;
        end
    end
`else
    assign align_err = 1'b0;

    logic unused_align;
    assign unused_align = align_err_d;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        er;
        logic [31:0] et;
        logic        ex;
        logic [31:0] exp_pc;
        logic        exp_pend;
        logic        exp_redir;
        logic        exp_align;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = '0;
    logic        eret_valid = 1'b0;
    logic [31:0] eret_target = '0;
    logic        exc_valid = 1'b0;
    logic [31:0] pc;
    logic        pending;
    logic        redirected;
    logic        align_err;

    int errors = 0;
    int checks = 0;

    vec_t vecs[$];
    vec_t sb[$];

    pc_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .eret_valid   (eret_valid),
        .eret_target  (eret_target),
        .exc_valid    (exc_valid),
        .pc           (pc),
        .pending      (pending),
        .redirected   (redirected),
        .align_err    (align_err)
    );

    always #5 clock = ~clock;

    // Watchdog so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h required %h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic stl, input logic br, input logic [31:0] bt,
                       input logic er, input logic [31:0] et, input logic ex,
                       input logic [31:0] epc, input logic epend, input logic eredir,
                       input logic ealign);
        vec_t v;
        v.rst = rst; v.stall = stl; v.br = br; v.bt = bt; v.er = er; v.et = et; v.ex = ex;
        v.exp_pc = epc; v.exp_pend = epend; v.exp_redir = eredir; v.exp_align = ealign;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] mis_pc0, mis_pc1;
        logic        mis_al;
        vec_t        v, e;
`ifdef PC_ALIGN_CHECK_EN
        mis_pc0 = 32'h0040_0004; mis_pc1 = 32'h0040_0008; mis_al = 1'b1;
`else
        mis_pc0 = 32'h0040_0102; mis_pc1 = 32'h0040_0106; mis_al = 1'b0;
`endif
        //   rst stl br bt            er et            ex  pc            pend red aln
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0040_0000, 0, 0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0040_0004, 0, 0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0040_0008, 0, 0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0040_000C, 0, 0, 0);
        add(0, 0, 1, 32'h0040_0100, 0, 32'h0,         0, 32'h0040_0100, 0, 1, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0040_0104, 0, 0, 0);
        // branch captured during a 3-cycle stall
        add(0, 1, 1, 32'h0040_0200, 0, 32'h0,         0, 32'h0040_0104, 1, 0, 0);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0040_0104, 1, 0, 0);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0040_0104, 1, 0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0040_0200, 0, 1, 0);
        // all three requests on one edge: exception wins
        add(0, 0, 1, 32'h0040_0400, 1, 32'h0040_0300, 1, 32'h0040_0004, 0, 1, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0040_0008, 0, 0, 0);
        // eret latched, later branch dropped
        add(0, 1, 0, 32'h0,         1, 32'h0040_0300, 0, 32'h0040_0008, 1, 0, 0);
        add(0, 1, 1, 32'h0040_0400, 0, 32'h0,         0, 32'h0040_0008, 1, 0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0040_0300, 0, 1, 0);
        // reset mid-stall discards the pending eret
        add(0, 1, 0, 32'h0,         1, 32'h0040_0500, 0, 32'h0040_0300, 1, 0, 0);
        add(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0040_0000, 0, 0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0040_0004, 0, 0, 0);
        // misaligned branch target
        add(0, 0, 1, 32'h0040_0102, 0, 32'h0,         0, mis_pc0,       0, 1, mis_al);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, mis_pc1,       0, 0, 0);
        // wrap-around
        add(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,         0, 32'hFFFF_FFFC, 0, 1, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0000, 0, 0, 0);
        // pending eret beats live branch at release
        add(0, 1, 0, 32'h0,         1, 32'h0040_0600, 0, 32'h0000_0000, 1, 0, 0);
        add(0, 0, 1, 32'h0040_0700, 0, 32'h0,         0, 32'h0040_0600, 0, 1, 0);
        // live eret beats pending branch at release
        add(0, 1, 1, 32'h0040_0800, 0, 32'h0,         0, 32'h0040_0600, 1, 0, 0);
        add(0, 0, 0, 32'h0,         1, 32'h0040_0900, 0, 32'h0040_0900, 0, 1, 0);
        // pending exception survives a later eret
        add(0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h0040_0900, 1, 0, 0);
        add(0, 1, 0, 32'h0,         1, 32'h0040_0A00, 0, 32'h0040_0900, 1, 0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0040_0004, 0, 1, 0);
        // equal priority at release: live branch wins
        add(0, 1, 1, 32'h0040_0B00, 0, 32'h0,         0, 32'h0040_0004, 1, 0, 0);
        add(0, 0, 1, 32'h0040_0C00, 0, 32'h0,         0, 32'h0040_0C00, 0, 1, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0040_0C04, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clock);
            reset = v.rst; stall = v.stall;
            branch_valid = v.br; branch_target = v.bt;
            eret_valid = v.er; eret_target = v.et; exc_valid = v.ex;
            sb.push_back(v);
            @(posedge clock);
            #1;
            if (sb.size() == 0) begin
                errors++; checks++;
                $display("FAIL scoreboard row %0d: got empty queue, required entry", i);
            end else begin
                e = sb.pop_front();
                check("pc", i, pc, e.exp_pc);
                check("pending", i, {31'b0, pending}, {31'b0, e.exp_pend});
                check("redirected", i, {31'b0, redirected}, {31'b0, e.exp_redir});
                check("align_err", i, {31'b0, align_err}, {31'b0, e.exp_align});
            end
        end

        // Asynchronous reset: it takes effect without a clock edge, mid-stall.
        @(negedge clock);
        reset = 1'b0; stall = 1'b1; branch_valid = 1'b1; branch_target = 32'h0040_0D00;
        eret_valid = 1'b0; exc_valid = 1'b0;
        @(posedge clock);
        #1;
        check("seq_pend", 100, {31'b0, pending}, 32'd1);
        check("seq_pc_hold", 100, pc, 32'h0040_0C04);
        #2;
        reset = 1'b1;
        #1;
        check("async_pc", 101, pc, 32'h0040_0000);
        check("async_pend", 101, {31'b0, pending}, 32'd0);
        @(negedge clock);
        reset = 1'b0; stall = 1'b0; branch_valid = 1'b0;
        @(posedge clock);
        #1;
        check("post_reset_pc", 102, pc, 32'h0040_0004);
        check("post_reset_redir", 102, {31'b0, redirected}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
